btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
- REQ-001: The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable-input cycles required to accept a press or release (10 ms at 100 MHz); legal range >= 2.
- REQ-002: The block SHALL have parameter REPEAT_DELAY, default 50000000, giving the held cycles from press acceptance to the first auto-repeat pulse; legal range >= 2.
- REQ-003: The block SHALL have parameter REPEAT_RATE, default 15000000, giving the held cycles between later auto-repeat pulses; legal range >= 2.
- REQ-004: The block SHALL have parameter REPEAT_EN, 5 bits, default 5'b01111, where bit i enables auto-repeat for button i.
- REQ-005: The block SHALL have port clk, input, 1 bit: system clock; all logic runs on its rising edge.
- REQ-006: The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-007: The block SHALL have port btn_raw, input, 5 bits: raw, asynchronous, bouncing buttons; bit order [0]=L, [1]=R, [2]=U, [3]=D, [4]=C.
- REQ-008: The block SHALL have port btn_level, output, 5 bits: debounced button state, 1 = held.
- REQ-009: The block SHALL have port btn_pulse, output, 5 bits: single-cycle press and auto-repeat strobes, for cursor_controller and game_state.

Function
- REQ-010: Each btn_raw bit SHALL pass through a 2-flop synchronizer; only the second flop output (sync[i]) feeds the FSM.
- REQ-011: The five channels SHALL be fully independent, each with its own FSM, debounce counter and repeat counter.
- REQ-012: Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1); repeat counter width SHALL be clog2(max(REPEAT_DELAY,REPEAT_RATE)+1); neither counter SHALL wrap.
- REQ-013: Each FSM SHALL have the states IDLE, CONFIRM_PRESS, PRESSED and CONFIRM_RELEASE.
- REQ-014: IDLE: btn_level[i]=0; sync[i]=1 -> CONFIRM_PRESS with dcnt=0.
- REQ-015: CONFIRM_PRESS: sync[i]=0 -> IDLE without a pulse; otherwise dcnt increments; sync[i]=1 with dcnt==DEBOUNCE_CYCLES-1 -> PRESSED.
- REQ-016: The CONFIRM_PRESS -> PRESSED edge SHALL register btn_pulse[i]=1 for exactly one cycle, set btn_level[i]=1 and clear rcnt.
- REQ-017: Press latency: btn_raw[i] rising before edge 1 and held stable SHALL give btn_pulse[i] and btn_level[i] high after edge DEBOUNCE_CYCLES+3.
- REQ-018: PRESSED: sync[i]=0 -> CONFIRM_RELEASE with dcnt=0; btn_level[i] stays 1.
- REQ-019: PRESSED with REPEAT_EN[i]=1: rcnt increments each cycle; at rcnt==REPEAT_DELAY-1 (first repeat) or REPEAT_RATE-1 (later repeats), btn_pulse[i]=1 for one cycle and rcnt=0.
- REQ-020: PRESSED with REPEAT_EN[i]=0: no further pulses while held.
- REQ-021: CONFIRM_RELEASE: sync[i]=1 -> PRESSED with no pulse and the repeat sequence restarted at REPEAT_DELAY; dcnt==DEBOUNCE_CYCLES-1 with sync[i]=0 -> IDLE and btn_level[i]=0.
- REQ-022: btn_pulse[i] SHALL never be high on two consecutive cycles; if several channels pulse in the same cycle, every pulse SHALL be output.
- REQ-023: All outputs SHALL be registered, with no combinational path from btn_raw.

Reset
- REQ-024: reset=0 SHALL immediately clear the synchronizers, counters, btn_level and btn_pulse, and put every FSM in IDLE.
- REQ-025: A button held through reset deassertion SHALL be treated as a new press: one pulse after DEBOUNCE_CYCLES+3 edges.
- REQ-026: Reset asserted mid-debounce or mid-repeat SHALL abort it without emitting a pulse.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5)
- REQ-027: btn_raw=5'b10000 held from cycle 0 -> btn_pulse=5'b10000 only after edge 7, btn_level[4]=1 from edge 7, and no further pulse because C has REPEAT_EN=0.
- REQ-028: btn_raw[0] toggled every 2 cycles for 40 cycles, then 0 -> btn_pulse[0] and btn_level[0] stay 0 throughout.
- REQ-029: btn_raw[2] held for 40 cycles -> pulses after edges 7, 17, 22, 27, 32, 37; then released -> btn_level[2] falls 7 edges after release.
- REQ-030: btn_raw[1] held, dropped low for 2 cycles in PRESSED, then held again -> btn_level[1] stays 1, there is no extra press pulse, and the next repeat comes REPEAT_DELAY after re-entering PRESSED.
- REQ-031: btn_raw=5'b00011 rising in the same cycle -> btn_pulse=5'b00011 in one cycle after edge 7.
- REQ-032: reset pulsed low for 1 cycle during CONFIRM_PRESS of btn[3] -> all outputs go to 0 immediately, and with btn_raw[3] still high, one pulse arrives 7 edges after reset release.

Source files
------------

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Debounces five raw push-buttons and turns them into a held level plus
//   single-cycle strobes. A strobe fires when a press is accepted and, for
//   channels with auto-repeat enabled, periodically while the button is held.
//
// Ports
//   clk        : system clock, rising-edge active
//   reset      : asynchronous, active-low reset
//   btn_raw    : raw bouncing buttons, [0]=L [1]=R [2]=U [3]=D [4]=C
//   btn_level  : debounced button state, 1 = held (registered)
//   btn_pulse  : one-cycle press / auto-repeat strobes (registered)
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_RATE     = 15000000,
    parameter logic [4:0]  REPEAT_EN       = 5'b01111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse
);

    localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RCNT_W = $clog2(RMAX + 1);

    localparam logic [DCNT_W-1:0] DC_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RR_LAST = RCNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } state_t;

    // Two-flop synchronizer; only sync_q is allowed to reach the FSMs.
    logic [4:0] sync_meta_q;
    logic [4:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= btn_raw;
            sync_q      <= sync_meta_q;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_ch
        state_t            state_q, state_d;
        logic [DCNT_W-1:0] dcnt_q, dcnt_d;
        logic [RCNT_W-1:0] rcnt_q, rcnt_d;
        logic              first_q, first_d;  // next repeat uses REPEAT_DELAY
        logic              level_q, level_d;
        logic              pulse_q, pulse_d;

        always_comb begin
            state_d = state_q;
            dcnt_d  = dcnt_q;
            rcnt_d  = rcnt_q;
            first_d = first_q;
            level_d = level_q;
            pulse_d = 1'b0;

            case (state_q)
                IDLE: begin
                    level_d = 1'b0;
                    if (sync_q[i]) begin
                        state_d = CONFIRM_PRESS;
                        dcnt_d  = '0;
                    end
                end

                CONFIRM_PRESS: begin
                    if (!sync_q[i]) begin
                        state_d = IDLE;
                    end else if (dcnt_q == DC_LAST) begin
                        state_d = PRESSED;
                        pulse_d = 1'b1;
                        level_d = 1'b1;
                        rcnt_d  = '0;
                        first_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!sync_q[i]) begin
                        state_d = CONFIRM_RELEASE;
                        dcnt_d  = '0;
                    end else if (REPEAT_EN[i]) begin
                        if (rcnt_q == (first_q ? RD_LAST : RR_LAST)) begin
                            pulse_d = 1'b1;
                            rcnt_d  = '0;
                            first_d = 1'b0;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end

                CONFIRM_RELEASE: begin
                    // A glitch back to 1 returns to PRESSED silently and
                    // restarts the repeat schedule from the initial delay.
                    if (sync_q[i]) begin
                        state_d = PRESSED;
                        rcnt_d  = '0;
                        first_d = 1'b1;
                    end else if (dcnt_q == DC_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                dcnt_q  <= '0;
                rcnt_q  <= '0;
                first_q <= 1'b1;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                dcnt_q  <= dcnt_d;
                rcnt_q  <= rcnt_d;
                first_q <= first_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

endmodule
